// File: rtl/task_pkg.sv
// Shared types and defaults for the task answer-path arbiter.
package task_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } task_arb_state_enum;

  localparam int TASK_ARB_N_TASKS     = 4;
  localparam int TASK_ARB_WDOG_CYCLES = 1024;

endpackage

// File: rtl/task_answer_rr_picker.sv
// Round-robin picker: first set request scanning upward from last+1, wrapping.
module task_answer_rr_picker #(
  parameter int N_TASKS = 4,
  parameter int IDX_W   = $clog2(N_TASKS)
) (
  input  logic [N_TASKS-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [N_TASKS-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);

  int   j;
  logic found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    j        = 0;
    for (int i = 1; i <= N_TASKS; i++) begin
      j = int'(last) + i;
      if (j >= N_TASKS) j = j - N_TASKS;
      if (!found && req[j]) begin
        found    = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/task_answer_arbiter.sv
// Round-robin arbiter sharing the manager answer handshake among task output blocks.
// Optional stall watchdog with o_timeout: define TASK_ARB_WATCHDOG_EN.
module task_answer_arbiter
  import task_pkg::*;
#(
  parameter int N_TASKS     = TASK_ARB_N_TASKS,
  parameter int DATA_W      = 8,
  parameter int SIZE_W      = 12,
  parameter int WDOG_CYCLES = TASK_ARB_WDOG_CYCLES
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_TASKS-1:0]        i_tanswer_ready,
  input  logic [N_TASKS*DATA_W-1:0] i_tdata,
  input  logic [N_TASKS-1:0]        i_tanswer_data_last,
  input  logic [N_TASKS*SIZE_W-1:0] i_packet_size_in_bytes,
  output logic [N_TASKS-1:0]        o_tmanager_ready,
  input  logic                      i_tmanager_ready,
  output logic                      o_tanswer_ready,
  output logic [DATA_W-1:0]         o_tdata,
  output logic                      o_tanswer_data_last,
  output logic [SIZE_W-1:0]         o_packet_size_in_bytes,
  output logic [N_TASKS-1:0]        o_grant,
  output logic                      o_busy,
`ifdef TASK_ARB_WATCHDOG_EN
  output logic                      o_timeout,
`endif
  output logic                      o_len_err
);

  localparam int IDX_W = $clog2(N_TASKS);

  task_arb_state_enum state_q, state_d;
  logic [IDX_W-1:0]   g_q, r_last;
  logic [SIZE_W-1:0]  r_size, r_beat_cnt, pick_size;
  logic [N_TASKS-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               beat, last_beat, wdog_fire;

  task_answer_rr_picker #(.N_TASKS(N_TASKS), .IDX_W(IDX_W)) u_picker (
    .req      (i_tanswer_ready),
    .last     (r_last),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    pick_size = '0;
    for (int k = 0; k < N_TASKS; k++)
      if (pick[k]) pick_size = i_packet_size_in_bytes[k*SIZE_W +: SIZE_W];
  end

`ifdef TASK_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] stall_cnt;

  // Fires on the WDOG_CYCLES-th consecutive non-beat cycle of a transfer.
  assign wdog_fire = (state_q == S_XFER) && !beat && (stall_cnt == WD_W'(WDOG_CYCLES - 1));
  assign o_timeout = wdog_fire;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || state_q != S_XFER || beat) stall_cnt <= '0;
    else                                      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign wdog_fire = 1'b0;
`endif

  // Output mux is one-hot AND-OR on the registered grant; grant is 0 outside S_XFER.
  always_comb begin
    state_d                = state_q;
    o_tanswer_ready        = 1'b0;
    o_tdata                = '0;
    o_tanswer_data_last    = 1'b0;
    o_tmanager_ready       = '0;
    o_packet_size_in_bytes = '0;
    for (int k = 0; k < N_TASKS; k++) begin
      if (o_grant[k] && state_q == S_XFER) begin
        o_tanswer_ready     = i_tanswer_ready[k];
        o_tdata             = i_tdata[k*DATA_W +: DATA_W];
        o_tanswer_data_last = i_tanswer_data_last[k];
        o_tmanager_ready[k] = i_tmanager_ready;
      end
    end
    beat      = o_tanswer_ready && i_tmanager_ready;
    last_beat = beat && o_tanswer_data_last;
    case (state_q)
      S_IDLE: if (|i_tanswer_ready) state_d = S_XFER;
      S_XFER: begin
        o_packet_size_in_bytes = r_size;
        if (last_beat || wdog_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      o_grant    <= '0;
      g_q        <= '0;
      r_last     <= IDX_W'(N_TASKS - 1);
      r_size     <= '0;
      r_beat_cnt <= '0;
      o_len_err  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      o_busy  <= (state_d == S_XFER);
      if (state_q == S_IDLE) begin
        if (|i_tanswer_ready) begin
          o_grant    <= pick;
          g_q        <= pick_idx;
          r_size     <= pick_size;
          r_beat_cnt <= '0;
        end
      end else begin
        if (beat) r_beat_cnt <= r_beat_cnt + 1'b1;
        if (last_beat && (r_beat_cnt + SIZE_W'(1) != r_size)) o_len_err <= 1'b1;
        if (last_beat || wdog_fire) begin
          r_last  <= g_q;
          o_grant <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_task_answer_arbiter.sv
// Directed self-checking bench for task_answer_arbiter (default 4 requesters).
module tb_task_answer_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 12;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [N-1:0]    treq, tlast, o_tmanager_ready, o_grant;
  logic [N*DW-1:0] tdata;
  logic [N*SW-1:0] tsize;
  logic            mgr, o_tanswer_ready, o_tanswer_data_last, o_busy, o_len_err;
  logic [DW-1:0]   o_tdata;
  logic [SW-1:0]   o_packet_size_in_bytes;
`ifdef TASK_ARB_WATCHDOG_EN
  logic            o_timeout;
`endif

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  task_answer_arbiter #(.N_TASKS(N), .DATA_W(DW), .SIZE_W(SW), .WDOG_CYCLES(8)) dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .i_tanswer_ready        (treq),
    .i_tdata                (tdata),
    .i_tanswer_data_last    (tlast),
    .i_packet_size_in_bytes (tsize),
    .o_tmanager_ready       (o_tmanager_ready),
    .i_tmanager_ready       (mgr),
    .o_tanswer_ready        (o_tanswer_ready),
    .o_tdata                (o_tdata),
    .o_tanswer_data_last    (o_tanswer_data_last),
    .o_packet_size_in_bytes (o_packet_size_in_bytes),
    .o_grant                (o_grant),
    .o_busy                 (o_busy),
`ifdef TASK_ARB_WATCHDOG_EN
    .o_timeout              (o_timeout),
`endif
    .o_len_err              (o_len_err)
  );

  task tick;
    @(posedge i_clk);
    #1;
  endtask

  task do_reset;
    i_rst_n = 1'b0;
    treq = '0; tlast = '0; tdata = '0; tsize = '0; mgr = 1'b0;
    tick; tick;
    i_rst_n = 1'b1;
  endtask

  task test_reset;
    treq = 4'b1111;
    i_rst_n = 1'b0;
    tick; tick;
    #1;
    checks++; if (o_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", o_grant); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err got=%b exp=0", o_len_err); end
    checks++; if ({o_tanswer_ready, o_tanswer_data_last, o_tmanager_ready, o_tdata, o_packet_size_in_bytes} !== '0) begin
      errors++; $display("FAIL reset_outputs got rdy=%b last=%b mrdy=%b data=%h size=%0d exp all 0",
        o_tanswer_ready, o_tanswer_data_last, o_tmanager_ready, o_tdata, o_packet_size_in_bytes);
    end
    do_reset;
  endtask

  task test_single;
    do_reset;
    mgr = 1'b1;
    treq[2] = 1'b1; tsize[2*SW +: SW] = 12'd5; tdata[2*DW +: DW] = 8'hA0;
    tick;
    checks++; if (o_grant !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", o_grant); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", o_busy); end
    checks++; if (o_packet_size_in_bytes !== 12'd5) begin errors++; $display("FAIL single_size got=%0d exp=5", o_packet_size_in_bytes); end
    for (int b = 0; b < 5; b++) begin
      tdata[2*DW +: DW] = 8'hA0 + 8'(b);
      tlast[2] = (b == 4);
      #1;
      checks++; if (o_tdata !== 8'hA0 + 8'(b) || o_tanswer_ready !== 1'b1) begin
        errors++; $display("FAIL single_data beat=%0d got=%h/%b exp=%h/1", b, o_tdata, o_tanswer_ready, 8'hA0 + 8'(b));
      end
      checks++; if (o_tanswer_data_last !== (b == 4) || o_tmanager_ready !== 4'b0100) begin
        errors++; $display("FAIL single_last beat=%0d got last=%b mrdy=%b exp last=%b mrdy=0100", b, o_tanswer_data_last, o_tmanager_ready, b == 4);
      end
      tick;
    end
    treq = '0; tlast = '0;
    #1;
    checks++; if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin errors++; $display("FAIL single_release got grant=%b busy=%b exp 0000/0", o_grant, o_busy); end
    checks++; if (o_len_err !== 1'b0) begin errors++; $display("FAIL single_len_err got=%b exp=0", o_len_err); end
    checks++; if (o_tanswer_ready !== 1'b0 || o_tdata !== 8'h00) begin errors++; $display("FAIL single_idle_mux got rdy=%b data=%h exp 0/00", o_tanswer_ready, o_tdata); end
  endtask

  task test_round_robin;
    logic [N-1:0] exp_two [3];
    logic [N-1:0] exp_all [9];
    exp_two = '{4'b0001, 4'b0000, 4'b0010};
    exp_all = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset;
    mgr = 1'b1; tlast = 4'b1111; tsize = {4{12'd1}};
    treq = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (o_grant !== exp_two[c]) begin errors++; $display("FAIL rr_two cycle=%0d got=%b exp=%b", c, o_grant, exp_two[c]); end
    end
    do_reset;
    mgr = 1'b1; tlast = 4'b1111; tsize = {4{12'd1}};
    treq = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      tick;
      checks++; if (o_grant !== exp_all[c]) begin errors++; $display("FAIL rr_all cycle=%0d got=%b exp=%b", c, o_grant, exp_all[c]); end
    end
    checks++; if (o_len_err !== 1'b0) begin errors++; $display("FAIL rr_len_err got=%b exp=0", o_len_err); end
  endtask

  task test_mgr_toggle;
    int beats;
    beats = 0;
    do_reset;
    treq[0] = 1'b1; tsize[SW-1:0] = 12'd4;
    tick;
    checks++; if (o_grant !== 4'b0001) begin errors++; $display("FAIL toggle_grant got=%b exp=0001", o_grant); end
    for (int c = 0; c < 12 && beats < 4; c++) begin
      mgr = (c % 2 == 0);
      tdata[DW-1:0] = 8'h10 + 8'(beats);
      tlast[0] = (beats == 3);
      #1;
      checks++; if (o_tmanager_ready !== (mgr ? 4'b0001 : 4'b0000) || o_tdata !== 8'h10 + 8'(beats)) begin
        errors++; $display("FAIL toggle_route cycle=%0d got mrdy=%b data=%h exp mrdy=%b data=%h",
          c, o_tmanager_ready, o_tdata, mgr ? 4'b0001 : 4'b0000, 8'h10 + 8'(beats));
      end
      if (mgr) beats++;
      tick;
    end
    treq = '0; tlast = '0; mgr = 1'b0;
    #1;
    checks++; if (beats !== 4 || o_grant !== 4'b0000) begin errors++; $display("FAIL toggle_end got beats=%0d grant=%b exp 4/0000", beats, o_grant); end
    checks++; if (o_len_err !== 1'b0) begin errors++; $display("FAIL toggle_len_err got=%b exp=0", o_len_err); end
  endtask

  task test_stall;
    do_reset;
    mgr = 1'b1;
    treq[1] = 1'b1; tsize[SW +: SW] = 12'd3;
    tick;
    tick;
    treq[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (o_grant !== 4'b0010 || o_busy !== 1'b1 || o_tanswer_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold cycle=%0d got grant=%b busy=%b rdy=%b exp 0010/1/0", c, o_grant, o_busy, o_tanswer_ready);
      end
      tick;
    end
    treq[1] = 1'b1;
    tick;
    tlast[1] = 1'b1;
    tick;
    treq = '0; tlast = '0;
    #1;
    checks++; if (o_grant !== 4'b0000 || o_len_err !== 1'b0) begin errors++; $display("FAIL stall_end got grant=%b len_err=%b exp 0000/0", o_grant, o_len_err); end
  endtask

  task test_len_err;
    do_reset;
    mgr = 1'b1;
    treq[3] = 1'b1; tsize[3*SW +: SW] = 12'd4;
    tick;
    checks++; if (o_grant !== 4'b1000) begin errors++; $display("FAIL lenerr_grant got=%b exp=1000", o_grant); end
    tick; tick;
    tlast[3] = 1'b1;
    #1;
    checks++; if (o_len_err !== 1'b0) begin errors++; $display("FAIL lenerr_before got=%b exp=0", o_len_err); end
    tick;
    checks++; if (o_len_err !== 1'b1 || o_grant !== 4'b0000) begin errors++; $display("FAIL lenerr_set got len_err=%b grant=%b exp 1/0000", o_len_err, o_grant); end
    tsize[3*SW +: SW] = 12'd2; tlast[3] = 1'b0;
    tick;
    checks++; if (o_grant !== 4'b1000 || o_packet_size_in_bytes !== 12'd2) begin
      errors++; $display("FAIL lenerr_regrant got grant=%b size=%0d exp 1000/2", o_grant, o_packet_size_in_bytes);
    end
    tick;
    tlast[3] = 1'b1;
    tick;
    treq = '0; tlast = '0;
    #1;
    checks++; if (o_len_err !== 1'b1 || o_grant !== 4'b0000) begin errors++; $display("FAIL lenerr_sticky got len_err=%b grant=%b exp 1/0000", o_len_err, o_grant); end
  endtask

  // Runs straight after test_len_err so len_err is already set going in.
  task test_reset_mid;
    mgr = 1'b1;
    treq = 4'b0001; tlast = 4'b0001; tsize = {36'd0, 12'd1};
    tick;
    checks++; if (o_grant !== 4'b0001) begin errors++; $display("FAIL midrst_pre0 got=%b exp=0001", o_grant); end
    tick;
    treq = 4'b0010; tlast = '0; tsize[SW +: SW] = 12'd6;
    tick;
    checks++; if (o_grant !== 4'b0010) begin errors++; $display("FAIL midrst_pre1 got=%b exp=0010", o_grant); end
    tick; tick;
    i_rst_n = 1'b0;
    treq = 4'b0011;
    tick;
    checks++; if (o_grant !== 4'b0000 || o_busy !== 1'b0 || o_len_err !== 1'b0) begin
      errors++; $display("FAIL midrst_clear got grant=%b busy=%b len_err=%b exp 0000/0/0", o_grant, o_busy, o_len_err);
    end
    checks++; if (o_tanswer_ready !== 1'b0 || o_tanswer_data_last !== 1'b0) begin
      errors++; $display("FAIL midrst_mux got rdy=%b last=%b exp 0/0", o_tanswer_ready, o_tanswer_data_last);
    end
    i_rst_n = 1'b1;
    tick;
    checks++; if (o_grant !== 4'b0001) begin errors++; $display("FAIL midrst_first got=%b exp=0001", o_grant); end
    do_reset;
  endtask

  initial begin
    i_rst_n = 1'b0;
    treq = '0; tlast = '0; tdata = '0; tsize = '0; mgr = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_mgr_toggle;
    test_stall;
    test_len_err;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
